branch_pred_ctrl: RTL and testbench
===================================

# branch_pred_ctrl

Branch prediction and redirect controller for the RV32I pipelined core. It holds a direct-mapped branch target buffer (BTB) with 2-bit saturating counters. The IF stage looks up the BTB for a predicted next PC. The EX stage feeds back the resolved branch outcome and the controller updates the tables. When a prediction is wrong, the controller raises a flush with the corrected PC. It also keeps branch and mispredict statistics counters.

## Interface
- ENTRY_BITS, 4, log2 of BTB entry count (16 entries); index = PC[ENTRY_BITS+1:2]
- TAG_W, derived = 30-ENTRY_BITS, tag = PC[31:ENTRY_BITS+2]; not overridable
- clk  in  1  core clock; all state updates on rising edge
- rst_n  in  1  asynchronous, active-low reset
- pc_if  in  32  PC currently in IF
- pred_taken  out  1  IF prediction: take branch
- pred_target  out  32  IF predicted next PC (target if pred_taken, else pc_if+4)
- ex_valid  in  1  instruction in EX is a conditional branch (br_type != NOBRANCH)
- ex_stall  in  1  EX held this cycle; suppresses update, flush and statistics
- ex_pc  in  32  PC of the EX branch
- ex_target  in  32  computed branch target (PC+imm)
- ex_br  in  1  resolved outcome from the branch decision unit
- ex_pred_taken  in  1  pred_taken carried down the pipeline with this instruction
- ex_pred_target  in  32  pred_target carried down the pipeline with this instruction
- flush  out  1  mispredict: squash IF/ID, load redirect_pc
- redirect_pc  out  32  corrected PC: ex_br ? ex_target : ex_pc+4
- stat_branches  out  32  resolved branch count
- stat_mispredicts  out  32  mispredict count

## Operation
- Per-entry state: valid (1), tag (TAG_W), target (32), ctr (2).
- Lookup is combinational on pc_if.
  - hit = valid[idx] && tag[idx]==pc_if[31:ENTRY_BITS+2].
  - pred_taken = hit && ctr[idx][1].
  - pred_target = pred_taken ? target[idx] : pc_if+4 (32-bit wrap).
- Resolve, combinational. act = ex_valid && !ex_stall && rst_n.
  - mispredict = act && ((ex_br != ex_pred_taken) || (ex_br && ex_pred_target != ex_target)).
  - flush = mispredict.
  - redirect_pc is always driven with the corrected PC; it is only meaningful when flush=1.
- Update at the clock edge when act=1, using the EX index/tag. Hit means the EX tag matches a valid entry.
  - Hit, ex_br=1: ctr = min(ctr+1, 3); target = ex_target.
  - Hit, ex_br=0: ctr = max(ctr-1, 0); target unchanged; entry stays valid.
  - Miss, ex_br=1: allocate the entry (valid=1, tag, target=ex_target, ctr=2'b10, weakly taken), evicting any prior occupant.
  - Miss, ex_br=0: no change.
- Statistics when act=1:
  - stat_branches += 1.
  - stat_mispredicts += 1 if mispredict.
  - Both saturate at 32'hFFFF_FFFF and do not wrap.
- Non-branch instructions (ex_valid=0) never touch the tables or counters.

## Timing
- Reset (rst_n low, asynchronous): all valid=0, ctr=2'b01, targets/tags=0, stat counters=0.
  - During reset: pred_taken=0, pred_target=pc_if+4, flush=0.
- Prediction latency: 0 cycles (same cycle as pc_if).
- Flush/redirect latency: 0 cycles, asserted in the same cycle the branch is in EX.
- Update visibility: the table write takes effect at the next rising edge. A lookup of the same index in the write cycle returns the pre-update contents; no bypass.
- ex_stall=1 holds everything. When the stall releases, the held branch resolves exactly once: one update, one count.
- Reset deasserted mid-operation returns to the cleared state. A branch in EX during reset is dropped: no flush, no update.
- Aliasing: the index is shared. A different tag at the same index reads as a miss; an allocation overwrites the previous entry.

## Test plan
- Cold miss taken:
  - After reset, branch at ex_pc=0x100, ex_br=1, ex_target=0x80, ex_pred_taken=0 -> flush=1, redirect_pc=0x80.
  - Next cycle, pc_if=0x100 -> pred_taken=1, pred_target=0x80.
  - stat_branches=1, stat_mispredicts=1.
- Counter saturation:
  - Resolve 0x100 taken 3 more times with correct prediction -> no flush, ctr=3.
  - Then resolve not-taken twice: first -> flush=1, redirect_pc=0x104, ctr=2; second resolves with ex_pred_taken=1 -> flush, ctr=1.
  - pc_if=0x100 -> pred_taken=0, pred_target=0x104.
- Target change: hit with ctr>=2, ex_pred_target=0x80, ex_target=0x40, ex_br=1 -> flush=1, redirect_pc=0x40; a subsequent lookup returns 0x40.
- Alias eviction:
  - With ENTRY_BITS=4, 0x100 is allocated.
  - Resolve 0x140 (same index) taken to 0x200 -> lookup 0x100 misses (pred_target=0x104); lookup 0x140 predicts 0x200.
- Stall and same-cycle read:
  - ex_valid=1, ex_stall=1 for 3 cycles with a mispredicting branch -> flush=0 and counters unchanged throughout.
  - On release -> single flush, stat_branches +1.
  - Lookup of the same index in that cycle shows old contents.
- Asynchronous reset mid-run: assert rst_n=0 between clock edges after several allocations -> pred_taken=0 immediately, stats=0, all entries miss after release.

Source files
------------

// File: rtl/branch_pred_ctrl_if.sv
// rtl/branch_pred_ctrl_if.sv - IF lookup, EX resolve and statistics bundle for branch_pred_ctrl
//
// Purpose: groups the signals exchanged between the pipeline and the branch
// prediction controller.
//   master : pipeline side (drives pc_if and the EX resolve fields)
//   slave  : controller side (drives prediction, flush/redirect and stats)
// Signals:
//   pc_if             PC in IF
//   pred_taken        IF prediction: take branch
//   pred_target       IF predicted next PC
//   ex_valid          EX holds a conditional branch
//   ex_stall          EX held this cycle
//   ex_pc             PC of the EX branch
//   ex_target         computed branch target
//   ex_br             resolved outcome
//   ex_pred_taken     prediction carried with the EX instruction
//   ex_pred_target    predicted target carried with the EX instruction
//   flush             mispredict: squash IF/ID
//   redirect_pc       corrected PC
//   stat_branches     resolved branch count
//   stat_mispredicts  mispredict count
interface branch_pred_ctrl_if;
  logic [31:0] pc_if;
  logic        pred_taken;
  logic [31:0] pred_target;
  logic        ex_valid;
  logic        ex_stall;
  logic [31:0] ex_pc;
  logic [31:0] ex_target;
  logic        ex_br;
  logic        ex_pred_taken;
  logic [31:0] ex_pred_target;
  logic        flush;
  logic [31:0] redirect_pc;
  logic [31:0] stat_branches;
  logic [31:0] stat_mispredicts;

  modport master (
    output pc_if, ex_valid, ex_stall, ex_pc, ex_target, ex_br,
           ex_pred_taken, ex_pred_target,
    input  pred_taken, pred_target, flush, redirect_pc,
           stat_branches, stat_mispredicts
  );

  modport slave (
    input  pc_if, ex_valid, ex_stall, ex_pc, ex_target, ex_br,
           ex_pred_taken, ex_pred_target,
    output pred_taken, pred_target, flush, redirect_pc,
           stat_branches, stat_mispredicts
  );
endinterface

// File: rtl/branch_pred_ctrl.sv
// rtl/branch_pred_ctrl.sv - direct-mapped BTB with 2-bit counters, redirect and statistics
//
// Purpose: combinational IF lookup of a direct-mapped branch target buffer,
// combinational EX mispredict detection with redirect, table update and
// saturating statistics at the rising clock edge.
// Ports:
//   clk    core clock
//   rst_n  asynchronous active-low reset
//   bp     branch_pred_ctrl_if.slave (lookup, resolve, flush, statistics)
module branch_pred_ctrl #(
  parameter int ENTRY_BITS = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  branch_pred_ctrl_if.slave   bp
);

  localparam int TAG_W   = 30 - ENTRY_BITS;
  localparam int ENTRIES = 1 << ENTRY_BITS;

  logic             r_valid  [ENTRIES];
  logic [TAG_W-1:0] r_tag    [ENTRIES];
  logic [31:0]      r_target [ENTRIES];
  logic [1:0]       r_ctr    [ENTRIES];
  logic [31:0]      r_stat_branches;
  logic [31:0]      r_stat_mispredicts;

  logic [ENTRY_BITS-1:0] w_if_idx;
  logic [TAG_W-1:0]      w_if_tag;
  logic                  w_if_hit;
  logic                  w_pred_taken;
  logic [ENTRY_BITS-1:0] w_ex_idx;
  logic [TAG_W-1:0]      w_ex_tag;
  logic                  w_ex_hit;
  logic                  w_act;
  logic                  w_mispredict;
  logic                  w_unused;

  // Byte-offset bits of a word-aligned PC carry no index or tag information.
  assign w_unused = &{1'b0, bp.pc_if[1:0], bp.ex_pc[1:0]};

  // IF lookup
  assign w_if_idx     = bp.pc_if[ENTRY_BITS+1:2];
  assign w_if_tag     = bp.pc_if[31:ENTRY_BITS+2];
  assign w_if_hit     = r_valid[w_if_idx] && (r_tag[w_if_idx] == w_if_tag);
  // Gating with rst_n keeps the prediction clean in the cycle reset asserts.
  assign w_pred_taken = rst_n && w_if_hit && r_ctr[w_if_idx][1];

  assign bp.pred_taken  = w_pred_taken;
  assign bp.pred_target = w_pred_taken ? r_target[w_if_idx] : bp.pc_if + 32'd4;

  // EX resolve
  assign w_ex_idx = bp.ex_pc[ENTRY_BITS+1:2];
  assign w_ex_tag = bp.ex_pc[31:ENTRY_BITS+2];
  assign w_ex_hit = r_valid[w_ex_idx] && (r_tag[w_ex_idx] == w_ex_tag);
  assign w_act    = bp.ex_valid && !bp.ex_stall && rst_n;

  // A taken branch also mispredicts when the carried target is stale.
  assign w_mispredict = w_act &&
                        ((bp.ex_br != bp.ex_pred_taken) ||
                         (bp.ex_br && (bp.ex_pred_target != bp.ex_target)));

  assign bp.flush       = w_mispredict;
  assign bp.redirect_pc = bp.ex_br ? bp.ex_target : bp.ex_pc + 32'd4;

  assign bp.stat_branches    = r_stat_branches;
  assign bp.stat_mispredicts = r_stat_mispredicts;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < ENTRIES; i++) begin
        r_valid[i]  <= 1'b0;
        r_tag[i]    <= '0;
        r_target[i] <= '0;
        r_ctr[i]    <= 2'b01;
      end
      r_stat_branches    <= '0;
      r_stat_mispredicts <= '0;
    end else if (w_act) begin
      if (w_ex_hit) begin
        if (bp.ex_br) begin
          r_ctr[w_ex_idx]    <= (r_ctr[w_ex_idx] == 2'b11) ? 2'b11 : r_ctr[w_ex_idx] + 2'b01;
          r_target[w_ex_idx] <= bp.ex_target;
        end else begin
          r_ctr[w_ex_idx]    <= (r_ctr[w_ex_idx] == 2'b00) ? 2'b00 : r_ctr[w_ex_idx] - 2'b01;
        end
      end else if (bp.ex_br) begin
        // Allocation evicts whatever alias occupied this index.
        r_valid[w_ex_idx]  <= 1'b1;
        r_tag[w_ex_idx]    <= w_ex_tag;
        r_target[w_ex_idx] <= bp.ex_target;
        r_ctr[w_ex_idx]    <= 2'b10;
      end

      if (r_stat_branches != 32'hFFFF_FFFF) begin
        r_stat_branches <= r_stat_branches + 32'd1;
      end
      if (w_mispredict && (r_stat_mispredicts != 32'hFFFF_FFFF)) begin
        r_stat_mispredicts <= r_stat_mispredicts + 32'd1;
      end
    end
  end

endmodule

// File: tb/tb_branch_pred_ctrl.sv
// tb/tb_branch_pred_ctrl.sv - directed self-checking bench for branch_pred_ctrl
module tb_branch_pred_ctrl;

  logic clk;
  logic rst_n;
  int   n_tests;
  int   n_fail;

  branch_pred_ctrl_if bp ();

  branch_pred_ctrl #(.ENTRY_BITS(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bp    (bp.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic ex_set(input logic v, input logic st, input logic [31:0] pc,
                        input logic [31:0] tgt, input logic br, input logic pt,
                        input logic [31:0] ptgt);
    bp.ex_valid       = v;
    bp.ex_stall       = st;
    bp.ex_pc          = pc;
    bp.ex_target      = tgt;
    bp.ex_br          = br;
    bp.ex_pred_taken  = pt;
    bp.ex_pred_target = ptgt;
  endtask

  task automatic ex_idle();
    ex_set(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0);
  endtask

  task automatic look(input string tag, input logic [31:0] pc,
                      input logic exp_taken, input logic [31:0] exp_tgt);
    bp.pc_if = pc;
    #1;
    chk({tag, "_taken"}, {31'd0, bp.pred_taken}, {31'd0, exp_taken});
    chk({tag, "_target"}, bp.pred_target, exp_tgt);
  endtask

  task automatic stats(input string tag, input int br, input int mis);
    chk({tag, "_branches"}, bp.stat_branches, br);
    chk({tag, "_mispredicts"}, bp.stat_mispredicts, mis);
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    rst_n   = 1'b0;
    bp.pc_if = 32'h100;
    // A mispredicting branch sits in EX throughout reset and must be dropped.
    ex_set(1'b1, 1'b0, 32'h100, 32'h80, 1'b1, 1'b0, 32'h104);
    @(negedge clk);
    #1;
    chk("rst_flush", {31'd0, bp.flush}, 32'd0);
    look("rst_look", 32'h100, 1'b0, 32'h104);
    stats("rst", 0, 0);
    tick();
    stats("rst_hold", 0, 0);
    look("rst_after_edge", 32'h100, 1'b0, 32'h104);
    rst_n = 1'b1;

    // Cold miss, taken: allocate ctr=2, flush to target.
    ex_set(1'b1, 1'b0, 32'h100, 32'h80, 1'b1, 1'b0, 32'h104);
    #1;
    chk("cold_flush", {31'd0, bp.flush}, 32'd1);
    chk("cold_redirect", bp.redirect_pc, 32'h80);
    look("cold_same_cycle", 32'h100, 1'b0, 32'h104);
    tick();
    ex_idle();
    look("cold_next", 32'h100, 1'b1, 32'h80);
    stats("cold", 1, 1);

    // Three correctly predicted taken resolves saturate ctr at 3.
    for (int i = 0; i < 3; i++) begin
      ex_set(1'b1, 1'b0, 32'h100, 32'h80, 1'b1, 1'b1, 32'h80);
      #1;
      chk("sat_flush", {31'd0, bp.flush}, 32'd0);
      tick();
    end
    ex_idle();
    stats("sat", 4, 1);

    // Not taken from ctr=3 -> ctr=2 (still predicts taken), mispredict.
    ex_set(1'b1, 1'b0, 32'h100, 32'h80, 1'b0, 1'b1, 32'h80);
    #1;
    chk("nt1_flush", {31'd0, bp.flush}, 32'd1);
    chk("nt1_redirect", bp.redirect_pc, 32'h104);
    tick();
    ex_idle();
    look("nt1_look", 32'h100, 1'b1, 32'h80);
    // Not taken again -> ctr=1, prediction flips to not taken.
    ex_set(1'b1, 1'b0, 32'h100, 32'h80, 1'b0, 1'b1, 32'h80);
    #1;
    chk("nt2_flush", {31'd0, bp.flush}, 32'd1);
    tick();
    ex_idle();
    look("nt2_look", 32'h100, 1'b0, 32'h104);
    stats("nt", 6, 3);

    // Back up to ctr=2, then a target change on a taken hit.
    ex_set(1'b1, 1'b0, 32'h100, 32'h80, 1'b1, 1'b0, 32'h104);
    tick();
    ex_set(1'b1, 1'b0, 32'h100, 32'h40, 1'b1, 1'b1, 32'h80);
    #1;
    chk("tgt_flush", {31'd0, bp.flush}, 32'd1);
    chk("tgt_redirect", bp.redirect_pc, 32'h40);
    tick();
    ex_idle();
    look("tgt_look", 32'h100, 1'b1, 32'h40);
    stats("tgt", 8, 5);

    // Alias 0x140 shares index 0 with 0x100 and evicts it.
    ex_set(1'b1, 1'b0, 32'h140, 32'h200, 1'b1, 1'b0, 32'h144);
    #1;
    chk("alias_redirect", bp.redirect_pc, 32'h200);
    tick();
    ex_idle();
    look("alias_old", 32'h100, 1'b0, 32'h104);
    look("alias_new", 32'h140, 1'b1, 32'h200);
    stats("alias", 9, 6);

    // Stalled mispredicting branch for 3 cycles: nothing happens.
    ex_set(1'b1, 1'b1, 32'h100, 32'h300, 1'b1, 1'b0, 32'h104);
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("stall_flush", {31'd0, bp.flush}, 32'd0);
      tick();
      stats("stall", 9, 6);
    end
    bp.ex_stall = 1'b0;
    #1;
    chk("release_flush", {31'd0, bp.flush}, 32'd1);
    chk("release_redirect", bp.redirect_pc, 32'h300);
    look("release_same_cycle", 32'h100, 1'b0, 32'h104);
    tick();
    ex_idle();
    stats("release", 10, 7);
    look("release_next", 32'h100, 1'b1, 32'h300);
    look("release_alias_gone", 32'h140, 1'b0, 32'h144);

    // Not-taken miss allocates nothing; idle EX touches nothing.
    ex_set(1'b1, 1'b0, 32'h208, 32'h20, 1'b0, 1'b0, 32'h20C);
    #1;
    chk("ntmiss_flush", {31'd0, bp.flush}, 32'd0);
    tick();
    ex_set(1'b0, 1'b0, 32'h208, 32'h20, 1'b1, 1'b0, 32'h20C);
    #1;
    chk("idle_flush", {31'd0, bp.flush}, 32'd0);
    tick();
    look("ntmiss_look", 32'h208, 1'b0, 32'h20C);
    stats("ntmiss", 11, 7);

    // Allocate 0x208, then reset asynchronously between edges.
    ex_set(1'b1, 1'b0, 32'h208, 32'h20, 1'b1, 1'b0, 32'h20C);
    tick();
    ex_idle();
    look("pre_rst", 32'h208, 1'b1, 32'h20);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_taken", {31'd0, bp.pred_taken}, 32'd0);
    chk("arst_target", bp.pred_target, 32'h20C);
    stats("arst", 0, 0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    look("post_rst_a", 32'h208, 1'b0, 32'h20C);
    look("post_rst_b", 32'h100, 1'b0, 32'h104);
    stats("post_rst", 0, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
